// File: rtl/dac_sample_deinterleave.sv
// Collects CHANNELS consecutive FIFO words into one multi-channel DAC sample and
// hands the complete sample to the DAC driver atomically on each request.
module dac_sample_deinterleave #(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 32,
    parameter int UNDERRUN_ZERO = 0,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                      i_capture_clk,
    input  logic                      i_reset,
    input  logic                      i_dac_fifo_open,
    input  logic                      i_dac_request,
    output logic [CHANNELS*WIDTH-1:0] o_dac_buffer,
    output logic                      o_dac_underrun,
    output logic                      o_dac_open,
    output logic [COUNT_WIDTH-1:0]    o_underrun_count,
    input  logic                      i_clear_count,
    output logic                      o_dac_rden,
    input  logic [WIDTH-1:0]          i_dac_fifo_data,
    input  logic                      i_dac_empty
);

    localparam int CW = $clog2(CHANNELS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CHANNELS);

    typedef enum logic [1:0] {
        CLOSED,
        PRIME,
        FILL,
        READY
    } state_t;

    state_t r_state;
    state_t w_nextState;

    (* ASYNC_REG = "TRUE" *) logic r_openMeta;
    (* ASYNC_REG = "TRUE" *) logic r_openSync;

    logic [CW-1:0]             r_issued;
    logic [CW-1:0]             r_received;
    logic                      r_wordInFlight;
    logic [WIDTH-1:0]          r_newData [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] r_buffer;
    logic [CHANNELS*WIDTH-1:0] w_packed;
    logic                      r_underrun;
    logic                      r_open;
    logic [COUNT_WIDTH-1:0]    r_count;

    logic w_reading;
    logic w_rden;
    logic w_lastLanding;
    logic w_accept;
    logic w_underrunEvent;

    // Reads are gated on FIFO occupancy so an underrun never shifts channel alignment.
    assign w_reading       = (r_state == PRIME) || (r_state == FILL);
    assign w_rden          = w_reading && (r_issued < FULL_CNT) && !i_dac_empty && r_openSync;
    assign w_lastLanding   = r_wordInFlight && (r_received == LAST_IDX);
    assign w_accept        = r_openSync && (r_state == READY) && i_dac_request;
    assign w_underrunEvent = r_openSync && (r_state == FILL) && i_dac_request;

    always_ff @(posedge i_capture_clk) begin
        if (i_reset) begin
            r_openMeta <= 1'b0;
            r_openSync <= 1'b0;
        end else begin
            r_openMeta <= i_dac_fifo_open;
            r_openSync <= r_openMeta;
        end
    end

    always_ff @(posedge i_capture_clk) begin
        if (i_reset) begin
            r_state <= CLOSED;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (!r_openSync) begin
            w_nextState = CLOSED;
        end else begin
            case (r_state)
                CLOSED:      w_nextState = PRIME;
                PRIME, FILL: if (w_lastLanding) w_nextState = READY;
                READY:       if (i_dac_request) w_nextState = FILL;
                default:     w_nextState = CLOSED;
            endcase
        end
    end

    // A close discards the partial sample along with any word still in flight.
    always_ff @(posedge i_capture_clk) begin
        if (i_reset || !r_openSync) begin
            r_issued       <= '0;
            r_received     <= '0;
            r_wordInFlight <= 1'b0;
        end else begin
            r_wordInFlight <= w_rden;
            if (w_accept) begin
                r_issued   <= '0;
                r_received <= '0;
            end else begin
                if (w_rden) begin
                    r_issued <= r_issued + CW'(1);
                end
                if (r_wordInFlight) begin
                    r_received <= r_received + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_capture_clk) begin
        if (i_reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_newData[c] <= '0;
            end
        end else if (r_wordInFlight && r_openSync) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (r_received == CW'(c)) begin
                    r_newData[c] <= i_dac_fifo_data;
                end
            end
        end
    end

    always_ff @(posedge i_capture_clk) begin
        if (i_reset || !r_openSync) begin
            r_open <= 1'b0;
        end else if ((r_state == PRIME) && w_lastLanding) begin
            r_open <= 1'b1;
        end
    end

    always_comb begin
        w_packed = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_packed[(CHANNELS-1-c)*WIDTH +: WIDTH] = r_newData[c];
        end
    end

    // The presented buffer survives a close; only reset or a zeroing underrun clears it.
    always_ff @(posedge i_capture_clk) begin
        if (i_reset) begin
            r_buffer   <= '0;
            r_underrun <= 1'b0;
            r_count    <= '0;
        end else begin
            r_underrun <= w_underrunEvent;
            if (w_accept) begin
                r_buffer <= w_packed;
            end else if (w_underrunEvent && (UNDERRUN_ZERO != 0)) begin
                r_buffer <= '0;
            end
            if (i_clear_count) begin
                r_count <= '0;
            end else if (w_underrunEvent && (r_count != '1)) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign o_dac_buffer     = r_buffer;
    assign o_dac_underrun   = r_underrun;
    assign o_dac_open       = r_open;
    assign o_underrun_count = r_count;
    assign o_dac_rden       = w_rden;

endmodule
